can_bus_harness: RTL and testbench
==================================

// Module: can_bus_harness
// PURPOSE
//  Parametrised, synthesisable CAN bus model for N nodes: wired-AND bus, propagation delay,
//  fault injection, per-node arbitration-loss flags, stuff-rule monitor and run-length timer.
//  Replaces point-to-point tx->rx loopback in bench and on-board self-test. Sits between
//  custom_can_node instances: each node's tx enters, every node's rx leaves.
// PARAMETERS
//  NODES    2    number of attached nodes (1..16)
//  DELAY    1    bus propagation delay in CLK cycles (>=1)
//  RUN_LEN  100  cycles counted before done asserts (>=1)
//  CNT_W    16   width of cycle_cnt; RUN_LEN < 2**CNT_W
// PORTS
//  CLK         in   1      system clock, all logic rising-edge
//  RST_N       in   1      synchronous reset, active low
//  run         in   1      cycle counter enable
//  bit_tick    in   1      one-cycle pulse at CAN bit sample point
//  node_en     in   NODES  1 = node connected to bus
//  node_tx     in   NODES  node transmit bits, 0 = dominant, 1 = recessive
//  fault_mode  in   2      0 none, 1 stuck dominant, 2 stuck recessive, 3 invert
//  arb_clr     in   1      clears all arb_lost flags
//  node_rx     out  NODES  per-node receive bit
//  bus_level   out  1      delayed bus level seen by nodes
//  arb_lost    out  NODES  sticky: node sent recessive, read dominant
//  stuff_err   out  1      one-cycle pulse: 6th consecutive equal sampled bit
//  cycle_cnt   out  CNT_W  cycles elapsed while run=1
//  done        out  1      sticky: cycle_cnt reached RUN_LEN
// BEHAVIOUR
//  Reset (RST_N=0 at edge): delay line all 1, node_rx all 1, bus_level=1, arb_lost=0,
//   stuff_err=0, run counter=0, stuff counter=0, cycle_cnt=0, done=0. Reset beats all inputs.
//  Bus: raw = &(node_tx | ~node_en); no node enabled -> raw=1 (recessive).
//  Fault applied to raw combinationally: mode1 ->0, mode2 ->1, mode3 ->~raw; mode change
//   takes effect on next stage-0 load, no glitch suppression.
//  Delay: DELAY-stage shift register; bus_level = last stage; latency node_tx->bus_level =
//   DELAY cycles exactly. node_rx[i] = node_en[i] ? bus_level : 1 (registered path, no extra lag).
//  Arbitration: per node a DELAY-stage tx delay line (reset 1) aligns own tx with bus_level.
//   On bit_tick: if node_en[i] & tx_dly[i]==1 & bus_level==0 -> arb_lost[i] set next cycle.
//   Sticky until arb_clr; arb_clr and set in same cycle -> set wins. Disabled node never sets.
//  Stuff monitor, on bit_tick only: compare bus_level with previous sample; equal -> run
//   counter +1 (saturating at 6), differ -> counter = 1. First tick after reset counter = 1.
//   stuff_err pulses one cycle when counter transitions 5->6; stays 0 while saturated at 6;
//   re-armed only after a differing sample. No tick -> counter and sample held.
//  Cycle counter: while run=1 and done=0, cycle_cnt +1 per cycle; when next value equals
//   RUN_LEN, done=1 same edge as cycle_cnt=RUN_LEN. After done, counter frozen, done held
//   until reset. run=0 holds count. No wrap possible (RUN_LEN < 2**CNT_W).
//  Reset mid-frame: all flags and delay stages discarded; bus returns recessive next cycle.
// TESTING
//  T1 NODES=2 DELAY=1: node0 tx 0, node1 tx 1 -> bus_level=0 one cycle later, node_rx=2'b00.
//  T2 DELAY=3: single 1->0 edge on node_tx[0] -> bus_level falls exactly 3 cycles later.
//  T3 node1 sends 1, node0 sends 0, bit_tick once -> arb_lost=2'b10; arb_clr -> 2'b00.
//  T4 six ticks with bus held 0 -> stuff_err single pulse after tick 6; 7th tick no pulse;
//     toggle bus, then 6 equal -> pulse again.
//  T5 fault_mode=1 all tx=1 -> bus_level=0; mode 3 -> inverted; node_en=0 -> node_rx=1.
//  T6 RUN_LEN=100, run=1 -> done rises when cycle_cnt=100, count frozen; RST_N low
//     mid-run -> cycle_cnt=0, done=0 next edge.

Source files
------------

// File: rtl/can_bus_harness_if.sv
// Bus-side signal bundle of the CAN bus harness: per-node enable and transmit
// bits going into the wired-AND bus, per-node receive bits and the delayed bus
// level coming back out.
interface can_bus_harness_if #(
   parameter int NODES = 2
);
   logic [NODES-1:0] node_en;
   logic [NODES-1:0] node_tx;
   logic [NODES-1:0] node_rx;
   logic             bus_level;

   // Node side (or bench) drives tx/enable and listens to rx/bus level
   modport master (
      output node_en,
      output node_tx,
      input  node_rx,
      input  bus_level
   );

   // Harness side resolves the bus and returns what every node hears
   modport slave (
      input  node_en,
      input  node_tx,
      output node_rx,
      output bus_level
   );
endinterface

// File: rtl/can_bus_harness.sv
// CAN bus model for NODES attached nodes: wired-AND bus with fault injection,
// DELAY-cycle propagation line, per-node arbitration-loss flags, a bit-stuffing
// rule monitor and a run-length cycle timer that raises a sticky done flag.
module can_bus_harness #(
   parameter int NODES   = 2,
   parameter int DELAY   = 1,
   parameter int RUN_LEN = 100,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             run,
   input  logic             bit_tick,
   input  logic [1:0]       fault_mode,
   input  logic             arb_clr,
   can_bus_harness_if.slave bus,
   output logic [NODES-1:0] arb_lost,
   output logic             stuff_err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             done
);

   localparam logic [2:0]       STUFF_MAX = 3'd6;
   localparam logic [2:0]       STUFF_PRE = 3'd5;
   localparam logic [CNT_W-1:0] RUN_END   = CNT_W'(RUN_LEN);

   logic             raw_s;
   logic             faulted_s;
   logic             bus_level_s;
   logic [NODES-1:0] tx_aligned_s;
   logic [NODES-1:0] arb_set_s;
   logic             sample_eq_s;
   logic [CNT_W-1:0] cycle_nxt_s;

   logic             bus_dly_r [DELAY];
   logic [NODES-1:0] tx_dly_r  [DELAY];
   logic [NODES-1:0] arb_lost_r;
   logic [2:0]       stuff_cnt_r;
   logic             sample_r;
   logic             stuff_err_r;
   logic [CNT_W-1:0] cycle_cnt_r;
   logic             done_r;

   // Resolve the wired-AND bus (disconnected nodes read as recessive) and apply the fault
   always_comb begin
      raw_s = &(bus.node_tx | ~bus.node_en);
      case (fault_mode)
         2'd0:    faulted_s = raw_s;
         2'd1:    faulted_s = 1'b0;
         2'd2:    faulted_s = 1'b1;
         2'd3:    faulted_s = ~raw_s;
         default: faulted_s = raw_s;
      endcase
   end

   // Propagation delay line for the bus level; the last stage is what the nodes hear
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int k = 0; k < DELAY; k++) begin
            bus_dly_r[k] <= 1'b1;
         end
      end else begin
         bus_dly_r[0] <= faulted_s;
         for (int k = 1; k < DELAY; k++) begin
            bus_dly_r[k] <= bus_dly_r[k-1];
         end
      end
   end

   // Matching delay line for each node's own tx so it lines up with the bus it produced
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int k = 0; k < DELAY; k++) begin
            tx_dly_r[k] <= {NODES{1'b1}};
         end
      end else begin
         tx_dly_r[0] <= bus.node_tx;
         for (int k = 1; k < DELAY; k++) begin
            tx_dly_r[k] <= tx_dly_r[k-1];
         end
      end
   end

   assign bus_level_s   = bus_dly_r[DELAY-1];
   assign tx_aligned_s  = tx_dly_r[DELAY-1];
   assign bus.bus_level = bus_level_s;
   // Receive bits come straight off the registered bus level, so they carry no extra lag
   assign bus.node_rx   = ~bus.node_en | {NODES{bus_level_s}};

   // Detect nodes that sent recessive but read dominant at the sample point
   always_comb begin
      if (bit_tick && !bus_level_s) begin
         arb_set_s = bus.node_en & tx_aligned_s;
      end else begin
         arb_set_s = {NODES{1'b0}};
      end
   end

   // Sticky arbitration-loss flags; a new loss in the clearing cycle still sets
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         arb_lost_r <= {NODES{1'b0}};
      end else if (arb_clr) begin
         arb_lost_r <= arb_set_s;
      end else begin
         arb_lost_r <= arb_lost_r | arb_set_s;
      end
   end

   assign sample_eq_s = (bus_level_s == sample_r);

   // Stuff monitor: count equal consecutive samples, pulse once on reaching six
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         stuff_cnt_r <= 3'd0;
         sample_r    <= 1'b1;
         stuff_err_r <= 1'b0;
      end else if (bit_tick) begin
         sample_r    <= bus_level_s;
         stuff_err_r <= (stuff_cnt_r == STUFF_PRE) && sample_eq_s;
         if ((stuff_cnt_r == 3'd0) || !sample_eq_s) begin
            stuff_cnt_r <= 3'd1;
         end else if (stuff_cnt_r != STUFF_MAX) begin
            stuff_cnt_r <= stuff_cnt_r + 3'd1;
         end else begin
            stuff_cnt_r <= stuff_cnt_r;
         end
      end else begin
         stuff_err_r <= 1'b0;
      end
   end

   assign cycle_nxt_s = cycle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

   // Run-length timer: counts enabled cycles and freezes once RUN_LEN is reached
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cycle_cnt_r <= {CNT_W{1'b0}};
         done_r      <= 1'b0;
      end else if (run && !done_r) begin
         cycle_cnt_r <= cycle_nxt_s;
         done_r      <= (cycle_nxt_s == RUN_END);
      end else begin
         cycle_cnt_r <= cycle_cnt_r;
         done_r      <= done_r;
      end
   end

   assign arb_lost  = arb_lost_r;
   assign stuff_err = stuff_err_r;
   assign cycle_cnt = cycle_cnt_r;
   assign done      = done_r;

endmodule

// File: tb/tb_can_bus_harness.sv
// Randomized scoreboard bench for can_bus_harness: the stimulus process drives
// one cycle of inputs, predicts the post-edge outputs from a queue-based model
// of the bus rules and pushes them; a monitor pops and compares each cycle.
module tb_can_bus_harness;
   localparam int NODES   = 3;
   localparam int DELAY   = 3;
   localparam int RUN_LEN = 100;
   localparam int CNT_W   = 16;

   typedef struct {
      logic             bus;
      logic [NODES-1:0] rx;
      logic [NODES-1:0] arb;
      logic             err;
      logic [CNT_W-1:0] cnt;
      logic             done;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             run;
   logic             bit_tick;
   logic [1:0]       fault_mode;
   logic             arb_clr;
   logic [NODES-1:0] arb_lost;
   logic             stuff_err;
   logic [CNT_W-1:0] cycle_cnt;
   logic             done;

   int total = 0;
   int bad   = 0;

   exp_t sb_q[$];

   // model state
   bit               m_bus_hist[$];
   logic [NODES-1:0] m_tx_hist[$];
   logic [NODES-1:0] m_arb;
   bit               m_err;
   int               m_run_len;
   bit               m_prev;
   int               m_cnt;
   bit               m_done;

   can_bus_harness_if #(.NODES(NODES)) bus_if ();

   can_bus_harness #(
      .NODES(NODES), .DELAY(DELAY), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .run        (run),
      .bit_tick   (bit_tick),
      .fault_mode (fault_mode),
      .arb_clr    (arb_clr),
      .bus        (bus_if.slave),
      .arb_lost   (arb_lost),
      .stuff_err  (stuff_err),
      .cycle_cnt  (cycle_cnt),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // One clock of stimulus plus the predicted outputs after the following rising edge
   task automatic step(input bit r, input bit rn, input bit tk, input logic [NODES-1:0] en,
                       input logic [NODES-1:0] tx, input logic [1:0] fm, input bit clr);
      bit cur_bus;
      bit raw;
      bit fb;
      logic [NODES-1:0] old_tx;
      logic [NODES-1:0] setm;
      exp_t e;
      @(negedge clk);
      #1;
      rst_n = r; run = rn; bit_tick = tk; bus_if.node_en = en; bus_if.node_tx = tx;
      fault_mode = fm; arb_clr = clr;
      if (!r) begin
         m_bus_hist.delete();
         m_tx_hist.delete();
         for (int k = 0; k < DELAY; k++) begin
            m_bus_hist.push_back(1'b1);
            m_tx_hist.push_back({NODES{1'b1}});
         end
         m_arb = '0; m_err = 0; m_run_len = 0; m_prev = 1; m_cnt = 0; m_done = 0;
      end else begin
         cur_bus = m_bus_hist[0];
         old_tx  = m_tx_hist[0];
         raw = 1'b1;
         for (int i = 0; i < NODES; i++) begin
            if (en[i] && (tx[i] == 1'b0)) raw = 1'b0;
         end
         if (fm == 2'd1)      fb = 1'b0;
         else if (fm == 2'd2) fb = 1'b1;
         else if (fm == 2'd3) fb = !raw;
         else                 fb = raw;
         void'(m_bus_hist.pop_front());
         m_bus_hist.push_back(fb);
         void'(m_tx_hist.pop_front());
         m_tx_hist.push_back(tx);
         setm = '0;
         if (tk && !cur_bus) setm = en & old_tx;
         if (clr) m_arb = '0;
         m_arb = m_arb | setm;
         m_err = 0;
         if (tk) begin
            if (m_run_len == 0 || cur_bus != m_prev) m_run_len = 1;
            else m_run_len = m_run_len + 1;
            m_err  = (m_run_len == 6);
            m_prev = cur_bus;
         end
         if (rn && !m_done) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == RUN_LEN) m_done = 1;
         end
      end
      e.bus  = m_bus_hist[0];
      e.rx   = ~en | {NODES{m_bus_hist[0]}};
      e.arb  = m_arb;
      e.err  = m_err;
      e.cnt  = CNT_W'(m_cnt);
      e.done = m_done;
      sb_q.push_back(e);
   endtask

   // Monitor: compare whatever the DUT presents against the oldest prediction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("bus_level", {31'd0, bus_if.bus_level}, {31'd0, e.bus});
            chk("node_rx",   {29'd0, bus_if.node_rx},   {29'd0, e.rx});
            chk("arb_lost",  {29'd0, arb_lost},         {29'd0, e.arb});
            chk("stuff_err", {31'd0, stuff_err},        {31'd0, e.err});
            chk("cycle_cnt", {16'd0, cycle_cnt},        {16'd0, e.cnt});
            chk("done",      {31'd0, done},             {31'd0, e.done});
         end
      end
   end

   initial begin
      logic [NODES-1:0] tx_hold;
      logic [NODES-1:0] en_v;
      logic [1:0]       fm_v;
      rst_n = 1'b0; run = 1'b0; bit_tick = 1'b0; fault_mode = 2'd0; arb_clr = 1'b0;
      bus_if.node_en = '0; bus_if.node_tx = '1;
      repeat (3) step(0, 0, 0, 3'b111, 3'b111, 2'd0, 0);
      // latency of a single falling edge through the delay line
      repeat (4) step(1, 0, 0, 3'b111, 3'b111, 2'd0, 0);
      repeat (5) step(1, 0, 0, 3'b111, 3'b110, 2'd0, 0);
      // arbitration loss: node1 recessive against node0 dominant, then clear
      repeat (3) step(1, 0, 0, 3'b111, 3'b110, 2'd0, 0);
      step(1, 0, 1, 3'b111, 3'b110, 2'd0, 0);
      repeat (2) step(1, 0, 0, 3'b111, 3'b110, 2'd0, 0);
      step(1, 0, 0, 3'b111, 3'b110, 2'd0, 1);
      // stuff rule: seven ticks on a held dominant bus, toggle, six more
      repeat (7) begin
         step(1, 0, 1, 3'b111, 3'b110, 2'd0, 0);
         step(1, 0, 0, 3'b111, 3'b110, 2'd0, 0);
      end
      repeat (4) step(1, 0, 0, 3'b111, 3'b111, 2'd0, 0);
      step(1, 0, 1, 3'b111, 3'b111, 2'd0, 0);
      repeat (4) step(1, 0, 0, 3'b111, 3'b110, 2'd0, 0);
      repeat (6) begin
         step(1, 0, 1, 3'b111, 3'b110, 2'd0, 0);
         step(1, 0, 0, 3'b111, 3'b110, 2'd0, 0);
      end
      // faults and disconnected nodes
      repeat (4) step(1, 0, 0, 3'b111, 3'b111, 2'd1, 0);
      repeat (4) step(1, 0, 0, 3'b111, 3'b111, 2'd3, 0);
      repeat (4) step(1, 0, 0, 3'b000, 3'b000, 2'd2, 0);
      repeat (4) step(1, 0, 0, 3'b000, 3'b000, 2'd0, 0);
      // run-length timer to done, hold, then reset mid-run
      repeat (110) step(1, 1, 0, 3'b111, 3'b111, 2'd0, 0);
      step(0, 1, 0, 3'b111, 3'b111, 2'd0, 0);
      repeat (20) step(1, 1, 0, 3'b111, 3'b111, 2'd0, 0);
      // randomized traffic
      tx_hold = 3'b111; fm_v = 2'd0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) tx_hold = NODES'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) fm_v = 2'($urandom_range(0, 3));
         en_v = ($urandom_range(0, 7) == 0) ? NODES'($urandom_range(0, 7)) : 3'b111;
         step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), en_v, tx_hold, fm_v,
              ($urandom_range(0, 19) == 0));
      end
      repeat (3) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
